// File: rtl/gray_codec_stream.sv
// gray_codec_stream: streaming binary<->Gray converter with valid/ready on both
// sides and a 2-entry output FIFO. Conversion happens at accept time and the
// converted word is what gets buffered.
// Optional feature: define GRAY_CODEC_STAT_EN to enable the 16-bit xfer_cnt
// output-transfer counter; otherwise xfer_cnt is tied to zero.

module gray_codec_stream #(
  parameter int unsigned DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_data,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_mode,
  output logic [15:0]         xfer_cnt
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned STAT_W  = 16;

  // Buffer state
  logic [DATA_LEN-1:0] mem_data [DEPTH];
  logic                mem_mode [DEPTH];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [CNT_W-1:0]    count;

  // Next-state values
  logic [DATA_LEN-1:0] mem_data_nxt [DEPTH];
  logic                mem_mode_nxt [DEPTH];
  logic                rd_ptr_nxt;
  logic                wr_ptr_nxt;
  logic [CNT_W-1:0]    count_nxt;

  logic                push;
  logic                pop;
  logic [DATA_LEN-1:0] conv_data;

  // Handshakes use only registered in_ready/out_valid, so there is no
  // combinational path from out_ready to in_ready and no same-cycle bypass.
  always_comb begin
    push = in_valid & in_ready;
    pop  = out_valid & out_ready;
  end

  // Convert the incoming word in the direction selected by in_mode
  always_comb begin
    conv_data = '0;
    if (!in_mode) begin
      conv_data = in_data ^ (in_data >> 1);
    end else begin
      conv_data[DATA_LEN-1] = in_data[DATA_LEN-1];
      for (int i = int'(DATA_LEN) - 2; i >= 0; i--) begin
        conv_data[i] = conv_data[i+1] ^ in_data[i];
      end
    end
  end

  // FIFO next state: storage, pointers and occupancy
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_data_nxt[i] = mem_data[i];
      mem_mode_nxt[i] = mem_mode[i];
    end
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;

    if (push) begin
      mem_data_nxt[wr_ptr] = conv_data;
      mem_mode_nxt[wr_ptr] = in_mode;
      wr_ptr_nxt           = ~wr_ptr;
    end
    if (pop) begin
      rd_ptr_nxt = ~rd_ptr;
    end

    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // State and registered outputs, derived from the next state so they line
  // up with the buffer contents in the cycle after each edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_mode[i] <= 1'b0;
      end
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data[i] <= mem_data_nxt[i];
        mem_mode[i] <= mem_mode_nxt[i];
      end
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      count     <= count_nxt;
      in_ready  <= (count_nxt != CNT_W'(DEPTH));
      out_valid <= (count_nxt != '0);
      out_data  <= mem_data_nxt[rd_ptr_nxt];
      out_mode  <= mem_mode_nxt[rd_ptr_nxt];
    end
  end

`ifdef GRAY_CODEC_STAT_EN
  logic [STAT_W-1:0] stat_cnt;

  // Count completed output transfers; wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else if (pop) begin
      stat_cnt <= stat_cnt + STAT_W'(1);
    end
  end

  assign xfer_cnt = stat_cnt;
`else
  assign xfer_cnt = STAT_W'(0);
`endif

endmodule

// File: tb/tb_gray_codec_stream.sv
// Directed self-checking bench for gray_codec_stream (DATA_LEN = 8).

module tb_gray_codec_stream;

  localparam int unsigned DATA_LEN = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_data;
  logic                in_mode;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_data;
  logic                out_mode;
  logic [15:0]         xfer_cnt;

  int checks   = 0;
  int failures = 0;

  gray_codec_stream #(.DATA_LEN(DATA_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] exp_xfer(input int n);
`ifdef GRAY_CODEC_STAT_EN
    return 16'(n);
`else
    return 16'h0000 & 16'(n);
`endif
  endfunction

  logic [DATA_LEN-1:0] prev_out;
  logic [DATA_LEN-1:0] g;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    #2;

    // Reset state
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_mode",  64'(out_mode),  64'd0);
    check("rst_xfer_cnt",  64'(xfer_cnt),  64'd0);

    // Latency and both conversion directions
    out_ready = 1'b1;
    in_valid  = 1'b1; in_data = 8'h2D; in_mode = 1'b0;
    step();
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_b2g",   64'(out_data),  64'h3B);
    check("lat_mode0", 64'(out_mode),  64'd0);
    in_data = 8'h3B; in_mode = 1'b1;
    step();
    check("lat_g2b",   64'(out_data),  64'h2D);
    check("lat_mode1", 64'(out_mode),  64'd1);
    in_valid = 1'b0;
    step();
    check("lat_drain", 64'(out_valid), 64'd0);
    check("lat_xfer",  64'(xfer_cnt),  64'(exp_xfer(2)));

    // Edge values
    do_reset();
    in_valid = 1'b1; in_data = 8'hFF; in_mode = 1'b0;
    step();
    check("edge_ff_b2g", 64'(out_data), 64'h80);
    in_data = 8'h80; in_mode = 1'b1;
    step();
    check("edge_80_g2b", 64'(out_data), 64'hFF);
    in_data = 8'h00; in_mode = 1'b0;
    step();
    check("edge_00_b2g", 64'(out_data), 64'h00);
    check("edge_00_valid", 64'(out_valid), 64'd1);
    in_data = 8'h00; in_mode = 1'b1;
    step();
    check("edge_00_g2b", 64'(out_data), 64'h00);
    check("edge_00_mode", 64'(out_mode), 64'd1);
    in_valid = 1'b0;
    step();
    check("edge_xfer", 64'(xfer_cnt), 64'(exp_xfer(4)));

    // Backpressure and full behaviour
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h01;
    step();
    check("bp_rdy1", 64'(in_ready), 64'd1);
    check("bp_out1", 64'(out_data), 64'h01);
    in_data = 8'h02;
    step();
    check("bp_full_rdy", 64'(in_ready), 64'd0);
    in_data = 8'h03;
    step();
    check("bp_held_rdy",  64'(in_ready),  64'd0);
    check("bp_held_data", 64'(out_data),  64'h01);
    check("bp_held_vld",  64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_pop1_data", 64'(out_data), 64'h03);
    check("bp_pop1_rdy",  64'(in_ready), 64'd1);
    step();
    check("bp_pop2_data", 64'(out_data),  64'h02);
    check("bp_pop2_vld",  64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();
    check("bp_empty", 64'(out_valid), 64'd0);
    check("bp_xfer",  64'(xfer_cnt),  64'(exp_xfer(3)));

    // Streaming binary -> Gray, one word per cycle
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1; in_mode = 1'b0;
    prev_out  = '0;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      step();
      g = 8'(i) ^ (8'(i) >> 1);
      check("str_b2g",   64'(out_data),  64'(g));
      check("str_vld",   64'(out_valid), 64'd1);
      check("str_rdy",   64'(in_ready),  64'd1);
      if (i > 0) check("str_1bit", 64'($countones(out_data ^ prev_out)), 64'd1);
      prev_out = out_data;
    end
    in_valid = 1'b0;
    step();
    check("str_drain", 64'(out_valid), 64'd0);
    check("str_xfer",  64'(xfer_cnt),  64'(exp_xfer(256)));

    // Streaming round trip Gray -> binary
    in_valid = 1'b1; in_mode = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i) ^ (8'(i) >> 1);
      step();
      check("rt_g2b", 64'(out_data), 64'(i));
    end
    in_valid = 1'b0;
    step();

    // Reset with a full buffer
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b0; in_data = 8'h55;
    step();
    in_data = 8'hAA;
    step();
    check("mrst_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0; out_ready = 1'b1; in_data = 8'h11;
    step();
    check("mrst_vld",  64'(out_valid), 64'd0);
    check("mrst_rdy",  64'(in_ready),  64'd1);
    check("mrst_data", 64'(out_data),  64'd0);
    check("mrst_xfer", 64'(xfer_cnt),  64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    check("mrst_gone", 64'(out_valid), 64'd0);
    check("mrst_xfer2", 64'(xfer_cnt), 64'd0);

`ifdef GRAY_CODEC_STAT_EN
    // Counter wrap: 65537 transfers leave xfer_cnt at 1
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1; in_mode = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("stat_wrap", 64'(xfer_cnt), 64'h0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
